// File: rtl/saida_pkg.sv
// Shared definitions for the output stage: FSM encoding and 7-segment pattern table.
package saida_pkg;

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    SUPERIOR = 2'd1,
    INFERIOR = 2'd2,
    FIM      = 2'd3
  } estado_t;

  // Active-high segment patterns {g,f,e,d,c,b,a}, entry 15 first.
  localparam logic [15:0][6:0] SEG_TAB = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/saida_if.sv
// Processor-side handshake of the output stage: request level, data word and done pulse.
interface saida_if;
  logic        controle;
  logic [31:0] dado;
  logic        pronto;

  modport master (output controle, output dado, input pronto);
  modport slave  (input controle, input dado, output pronto);
endinterface

// File: rtl/saida_decodificador_7seg.sv
// Hex nibble to 7-segment decoder with selectable segment-on polarity.
module decodificador_7seg
  import saida_pkg::*;
#(
  parameter logic SEG_ATIVO = 1'b0
) (
  input  logic [3:0] nibble,
  output logic [6:0] segs
);

  always_comb begin
    segs = SEG_TAB[nibble];
    if (!SEG_ATIVO) segs = ~segs;
  end

endmodule

// File: rtl/saida.sv
// Output stage: latches a 32-bit word and shows it as two 16-bit halves, stepped by the
// operator through a debounced ch0 handshake, then pulses pronto.
module saida
  import saida_pkg::*;
#(
  parameter logic [19:0] DEBOUNCE  = 20'd500000,
  parameter logic        SEG_ATIVO = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  saida_if.slave      cpu,
  input  logic        ch0,
  output logic [15:0] leds,
  output logic [6:0]  hex3,
  output logic [6:0]  hex2,
  output logic [6:0]  hex1,
  output logic [6:0]  hex0,
  output logic        sup,
  output logic        inf
);

  logic        ch0_s1, ch0_s2, ch0_filt, ch0_filt_ant;
  logic [19:0] cnt;
  logic        sobe, desce;

  estado_t     estado_q, estado_d;
  logic [31:0] palavra_q;
  logic [15:0] leds_q;
  logic        sup_q, inf_q, pronto_q;
  logic        carrega, avanca;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ch0_s1       <= 1'b0;
      ch0_s2       <= 1'b0;
      ch0_filt     <= 1'b0;
      ch0_filt_ant <= 1'b0;
      cnt          <= '0;
    end else begin
      ch0_s1       <= ch0;
      ch0_s2       <= ch0_s1;
      ch0_filt_ant <= ch0_filt;
      if (ch0_s2 == ch0_filt) begin
        cnt <= '0;
      end else if (cnt == DEBOUNCE - 20'd1) begin
        ch0_filt <= ch0_s2;
        cnt      <= '0;
      end else begin
        cnt <= cnt + 20'd1;
      end
    end
  end

  assign sobe  = ch0_filt & ~ch0_filt_ant;
  assign desce = ~ch0_filt & ch0_filt_ant;

  always_comb begin
    estado_d = estado_q;
    carrega  = 1'b0;
    avanca   = 1'b0;
    unique case (estado_q)
      OCIOSO: begin
        if (cpu.controle && !ch0_filt) begin
          estado_d = SUPERIOR;
          carrega  = 1'b1;
        end
      end
      SUPERIOR: begin
        if (!cpu.controle) begin
          estado_d = OCIOSO;
        end else if (sobe) begin
          estado_d = INFERIOR;
          avanca   = 1'b1;
        end
      end
      INFERIOR: begin
        if (!cpu.controle) estado_d = OCIOSO;
        else if (desce)    estado_d = FIM;
      end
      FIM:     estado_d = OCIOSO;
      default: estado_d = OCIOSO;
    endcase
  end

  // Flags are computed from the next state so they line up with the state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q  <= OCIOSO;
      palavra_q <= '0;
      leds_q    <= '0;
      sup_q     <= 1'b0;
      inf_q     <= 1'b0;
      pronto_q  <= 1'b0;
    end else begin
      estado_q <= estado_d;
      sup_q    <= (estado_d == SUPERIOR);
      inf_q    <= (estado_d == INFERIOR);
      pronto_q <= (estado_d == FIM);
      if (carrega) begin
        palavra_q <= cpu.dado;
        leds_q    <= cpu.dado[31:16];
      end else if (avanca) begin
        leds_q <= palavra_q[15:0];
      end
    end
  end

  assign leds       = leds_q;
  assign sup        = sup_q;
  assign inf        = inf_q;
  assign cpu.pronto = pronto_q;

  decodificador_7seg #(.SEG_ATIVO(SEG_ATIVO)) u_hex3 (.nibble(leds_q[15:12]), .segs(hex3));
  decodificador_7seg #(.SEG_ATIVO(SEG_ATIVO)) u_hex2 (.nibble(leds_q[11:8]),  .segs(hex2));
  decodificador_7seg #(.SEG_ATIVO(SEG_ATIVO)) u_hex1 (.nibble(leds_q[7:4]),   .segs(hex1));
  decodificador_7seg #(.SEG_ATIVO(SEG_ATIVO)) u_hex0 (.nibble(leds_q[3:0]),   .segs(hex0));

endmodule

// File: tb/tb_saida.sv
// Directed bench for saida with a short debounce; expected values are hand-derived.
module tb_saida;

  localparam logic [19:0] DEB = 20'd4;
  // Active-low digit patterns
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;

  logic        clock = 1'b0;
  logic        reset;
  logic        ch0;
  logic [15:0] leds;
  logic [6:0]  hex3, hex2, hex1, hex0;
  logic        sup, inf;

  int tests = 0;
  int fails = 0;
  int pronto_cnt = 0;
  int pronto_ref;
  bit visto;

  saida_if cpu_if ();

  saida #(.DEBOUNCE(DEB), .SEG_ATIVO(1'b0)) dut (
    .clock (clock),
    .reset (reset),
    .cpu   (cpu_if.slave),
    .ch0   (ch0),
    .leds  (leds),
    .hex3  (hex3),
    .hex2  (hex2),
    .hex1  (hex1),
    .hex0  (hex0),
    .sup   (sup),
    .inf   (inf)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (cpu_if.pronto === 1'b1) pronto_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Settles a ch0 change through sync, debounce and the FSM reaction.
  task automatic set_ch0(input logic v);
    ch0 = v;
    tick(8);
  endtask

  // Waits a bounded time for pronto and drops controle on the pulse.
  task automatic wait_pronto(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clock);
      if (cpu_if.pronto === 1'b1) begin
        seen = 1'b1;
        cpu_if.controle = 1'b0;
      end
    end
  endtask

  initial begin
    reset           = 1'b0;
    ch0             = 1'b0;
    cpu_if.controle = 1'b0;
    cpu_if.dado     = '0;
    tick(2);
    check("rst_leds", leds, 0);
    check("rst_sup", sup, 0);
    check("rst_inf", inf, 0);
    check("rst_pronto", cpu_if.pronto, 0);
    check("rst_hex3", hex3, SEG_0);
    check("rst_hex0", hex0, SEG_0);
    reset = 1'b1;
    tick(2);

    // Full transfer of DEADBEEF
    cpu_if.controle = 1'b1;
    cpu_if.dado     = 32'hDEAD_BEEF;
    tick(1);
    check("t2_sup", sup, 1);
    check("t2_inf", inf, 0);
    check("t2_leds_hi", leds, 16'hDEAD);
    check("t2_hex3", hex3, SEG_D);
    check("t2_hex2", hex2, SEG_E);
    check("t2_hex1", hex1, SEG_A);
    check("t2_hex0", hex0, SEG_D);

    // Later dado changes must not reach the display
    cpu_if.dado = 32'h1234_5678;
    tick(3);
    check("t6_leds_hold", leds, 16'hDEAD);

    // Two-cycle glitch is filtered out
    ch0 = 1'b1;
    tick(2);
    ch0 = 1'b0;
    tick(10);
    check("t3_sup", sup, 1);
    check("t3_inf", inf, 0);
    check("t3_leds", leds, 16'hDEAD);

    set_ch0(1'b1);
    check("t2_inf_after_rise", inf, 1);
    check("t2_sup_after_rise", sup, 0);
    check("t2_leds_lo", leds, 16'hBEEF);
    check("t6_leds_lo_old", leds, 16'hBEEF);

    pronto_ref = pronto_cnt;
    ch0 = 1'b0;
    wait_pronto(visto);
    check("t2_pronto_seen", visto, 1);
    tick(4);
    check("t2_pronto_once", pronto_cnt - pronto_ref, 1);
    check("t2_leds_kept", leds, 16'hBEEF);
    check("t2_idle_inf", inf, 0);
    check("t2_idle_sup", sup, 0);

    // controle with ch0 already high: wait for its fall before latching
    set_ch0(1'b1);
    cpu_if.controle = 1'b1;
    cpu_if.dado     = 32'hAAAA_5555;
    tick(3);
    check("t4_no_latch_sup", sup, 0);
    check("t4_no_latch_leds", leds, 16'hBEEF);
    cpu_if.dado = 32'h0F0F_1111;
    set_ch0(1'b0);
    check("t4_sup", sup, 1);
    check("t4_leds", leds, 16'h0F0F);

    // Abort in INFERIOR
    set_ch0(1'b1);
    check("t5_inf", inf, 1);
    check("t5_leds_lo", leds, 16'h1111);
    pronto_ref = pronto_cnt;
    cpu_if.controle = 1'b0;
    tick(2);
    check("t5_abort_inf", inf, 0);
    check("t5_abort_sup", sup, 0);
    check("t5_abort_leds", leds, 16'h1111);
    check("t5_abort_no_pronto", pronto_cnt - pronto_ref, 0);
    set_ch0(1'b0);
    cpu_if.dado     = 32'h0000_0001;
    cpu_if.controle = 1'b1;
    tick(1);
    check("t5_new_sup", sup, 1);
    check("t5_new_hi", leds, 16'h0000);
    set_ch0(1'b1);
    check("t5_new_lo", leds, 16'h0001);
    check("t5_new_hex0", hex0, SEG_1);
    set_ch0(1'b0);
    check("t5_done_pronto", pronto_cnt - pronto_ref, 1);
    cpu_if.controle = 1'b0;
    tick(3);

    // Reset in the middle of SUPERIOR
    cpu_if.controle = 1'b1;
    cpu_if.dado     = 32'hCAFE_F00D;
    tick(2);
    check("t1_pre_sup", sup, 1);
    check("t1_pre_leds", leds, 16'hCAFE);
    pronto_ref = pronto_cnt;
    reset = 1'b0;
    #1;
    check("t1_async_sup", sup, 0);
    check("t1_async_leds", leds, 0);
    check("t1_async_pronto", cpu_if.pronto, 0);
    cpu_if.controle = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(2);
    check("t1_post_sup", sup, 0);
    check("t1_post_no_pronto", pronto_cnt - pronto_ref, 0);
    cpu_if.dado     = 32'h5A5A_0000;
    cpu_if.controle = 1'b1;
    tick(1);
    check("t1_idle_latch", sup, 1);
    check("t1_idle_leds", leds, 16'h5A5A);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
